// File: rtl/synapse_integrator.sv
// synapse_integrator: per-timestep synaptic integration for one neuron.
// A start pulse snapshots the axon spike vector. The block then scans every
// axon once and accumulates the weights of the set axons, which are read from
// an external synchronous weight memory. Leak is applied and the result is
// saturated and compared against threshold. The outcome is a registered
// potential plus one-cycle fire/done pulses.
module synapse_integrator #(
  parameter int AXON_CNT_BIT_WIDTH = 1,
  parameter int WEIGHT_WIDTH       = 16,
  parameter int POTENTIAL_WIDTH    = 16,
  parameter int THRESHOLD          = 10,
  parameter int LEAK               = 1,
  parameter int RESET_POTENTIAL    = 0
) (
  input  logic                                 neuron_clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [(1<<AXON_CNT_BIT_WIDTH)-1:0]   spike,
  output logic                                 weight_rd_en,
  output logic [AXON_CNT_BIT_WIDTH-1:0]        weight_addr,
  input  logic [WEIGHT_WIDTH-1:0]              weight_data,
  output logic [POTENTIAL_WIDTH-1:0]           potential,
  output logic                                 fire,
  output logic                                 done,
  output logic                                 busy
);

  localparam int N  = 1 << AXON_CNT_BIT_WIDTH;
  // Accumulator holds N weights with headroom, so it can never overflow.
  localparam int AW = WEIGHT_WIDTH + AXON_CNT_BIT_WIDTH + 1;
  // Sum width covers potential + acc - leak without wrap.
  localparam int SW = ((POTENTIAL_WIDTH > AW) ? POTENTIAL_WIDTH : AW) + 2;

  localparam logic signed [SW-1:0] LEAK_S = SW'(LEAK);
  localparam logic signed [SW-1:0] P_MAX  =
    {{(SW-POTENTIAL_WIDTH+1){1'b0}}, {(POTENTIAL_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] P_MIN  =
    {{(SW-POTENTIAL_WIDTH+1){1'b1}}, {(POTENTIAL_WIDTH-1){1'b0}}};
  localparam logic signed [POTENTIAL_WIDTH-1:0] TH_S   = POTENTIAL_WIDTH'(THRESHOLD);
  localparam logic signed [POTENTIAL_WIDTH-1:0] RST_S  = POTENTIAL_WIDTH'(RESET_POTENTIAL);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0]     LAST_IDX = {AXON_CNT_BIT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t                              state_reg;
  state_t                              state_next;
  logic [N-1:0]                        snap_reg;
  logic [AXON_CNT_BIT_WIDTH-1:0]       idx_reg;
  logic                                rd_pend_reg;
  logic signed [AW-1:0]                acc_reg;
  logic signed [POTENTIAL_WIDTH-1:0]   potential_reg;
  logic                                fire_reg;
  logic                                done_reg;

  logic signed [AW-1:0]                weight_ext;
  logic signed [SW-1:0]                sum_full;
  logic signed [POTENTIAL_WIDTH-1:0]   sat;

  // State register.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A start seen outside IDLE is dropped, not queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx_reg == LAST_IDX) state_next = DRAIN;
      DRAIN:   state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: one memory slot per axon, read only for snapshot bits that are set.
  always_comb begin
    weight_rd_en = (state_reg == SCAN) && snap_reg[idx_reg];
    weight_addr  = idx_reg;
    busy         = (state_reg != IDLE);
  end

  // Weight sign extension and leak/saturation arithmetic for the update step.
  always_comb begin
    weight_ext = {{(AW-WEIGHT_WIDTH){weight_data[WEIGHT_WIDTH-1]}}, weight_data};
    sum_full   = $signed({{(SW-POTENTIAL_WIDTH){potential_reg[POTENTIAL_WIDTH-1]}}, potential_reg})
               + $signed({{(SW-AW){acc_reg[AW-1]}}, acc_reg})
               - LEAK_S;
    if (sum_full > P_MAX) begin
      sat = P_MAX[POTENTIAL_WIDTH-1:0];
    end else if (sum_full < P_MIN) begin
      sat = P_MIN[POTENTIAL_WIDTH-1:0];
    end else begin
      sat = sum_full[POTENTIAL_WIDTH-1:0];
    end
  end

  // Snapshot, scan index, read-pending flag and accumulator.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_reg    <= '0;
      idx_reg     <= '0;
      rd_pend_reg <= 1'b0;
      acc_reg     <= '0;
    end else begin
      // Memory data lands one cycle after the strobe, so remember the strobe.
      rd_pend_reg <= weight_rd_en;
      if (state_reg == IDLE && start) begin
        snap_reg <= spike;
        idx_reg  <= '0;
        acc_reg  <= '0;
      end else begin
        if (state_reg == SCAN) begin
          idx_reg <= idx_reg + 1'b1;
        end
        if (rd_pend_reg) begin
          acc_reg <= acc_reg + weight_ext;
        end
      end
    end
  end

  // Membrane potential update with threshold fire and reset.
  always_ff @(posedge neuron_clk or negedge rst_n) begin
    if (!rst_n) begin
      potential_reg <= '0;
      fire_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      fire_reg <= 1'b0;
      done_reg <= 1'b0;
      if (state_reg == UPDATE) begin
        done_reg <= 1'b1;
        if (sat >= TH_S) begin
          potential_reg <= RST_S;
          fire_reg      <= 1'b1;
        end else begin
          potential_reg <= sat;
        end
      end
    end
  end

  assign potential = potential_reg;
  assign fire      = fire_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_synapse_integrator.sv
// Bench for synapse_integrator. Two instances share the stimulus: unit 0 has
// THRESHOLD=10 and unit 1 has THRESHOLD=32767. A behavioural model predicts
// each timestep's outcome, and the prediction is queued when start is issued.
// Per-unit monitors pop the queue on every done pulse and compare.
module tb_synapse_integrator;
  localparam int ACW  = 2;
  localparam int N    = 4;
  localparam int WW   = 16;
  localparam int PW   = 16;
  localparam int LEAK = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  start;
  logic [N-1:0]          spike;
  logic                  rd_en0, rd_en1;
  logic [ACW-1:0]        addr0, addr1;
  logic [WW-1:0]         wd0, wd1;
  logic [PW-1:0]         pot0, pot1;
  logic                  fire0, fire1, done0, done1, busy0, busy1;

  int w [N];

  // Synchronous weight memories: data one cycle after the strobe, X otherwise.
  always @(posedge clk) wd0 <= rd_en0 ? WW'(w[addr0]) : 'x;
  always @(posedge clk) wd1 <= rd_en1 ? WW'(w[addr1]) : 'x;

  synapse_integrator #(.AXON_CNT_BIT_WIDTH(ACW), .WEIGHT_WIDTH(WW), .POTENTIAL_WIDTH(PW),
                       .THRESHOLD(10), .LEAK(LEAK), .RESET_POTENTIAL(0)) u_dut0 (
    .neuron_clk(clk), .rst_n(rst_n), .start(start), .spike(spike),
    .weight_rd_en(rd_en0), .weight_addr(addr0), .weight_data(wd0),
    .potential(pot0), .fire(fire0), .done(done0), .busy(busy0));

  synapse_integrator #(.AXON_CNT_BIT_WIDTH(ACW), .WEIGHT_WIDTH(WW), .POTENTIAL_WIDTH(PW),
                       .THRESHOLD(32767), .LEAK(LEAK), .RESET_POTENTIAL(0)) u_dut1 (
    .neuron_clk(clk), .rst_n(rst_n), .start(start), .spike(spike),
    .weight_rd_en(rd_en1), .weight_addr(addr1), .weight_data(wd1),
    .potential(pot1), .fire(fire1), .done(done1), .busy(busy1));

  typedef struct {
    int           pot;
    bit           fire;
    logic [N-1:0] mask;
    int           cyc;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           dones [2] = '{0, 0};
  logic [N-1:0] mask [2] = '{'0, '0};
  int           model_pot [2] = '{0, 0};
  int           ths [2] = '{10, 32767};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum the weights of set axons, subtract leak, clamp, then threshold.
  function automatic void model(input logic [N-1:0] sp, input int th, input int pin,
                                output int pout, output bit f);
    int acc = 0;
    int s;
    for (int k = 0; k < N; k++) if (sp[k]) acc += w[k];
    s = pin + acc - LEAK;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    f    = (s >= th);
    pout = f ? 0 : s;
  endfunction

  task automatic on_done(input int u, input int p, input bit f, input bit b, input logic [N-1:0] m);
    exp_t e;
    if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done u%0d: got done=1 expected no done", u);
      return;
    end
    e = (u == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("u%0d potential", u), p, e.pot);
    chk($sformatf("u%0d fire", u), f, e.fire);
    chk($sformatf("u%0d read_mask", u), m, e.mask);
    // start is driven just before E0; done is visible after E_{N+2}.
    chk($sformatf("u%0d latency", u), cyc - e.cyc, N + 3);
    chk($sformatf("u%0d busy_at_done", u), b, 0);
    $display("step u%0d: spike_mask=%b potential=%0d fire=%0b", u, m, p, f);
    dones[u]++;
  endtask

  // Monitors: collect read addresses per timestep and score each done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      mask[0] = '0;
      mask[1] = '0;
    end else begin
      if (rd_en0) mask[0][addr0] = 1'b1;
      if (rd_en1) mask[1][addr1] = 1'b1;
      if (done0) begin
        on_done(0, int'($signed(pot0)), fire0, busy0, mask[0]);
        mask[0] = '0;
      end else if (fire0) begin
        checks++; errors++;
        $display("FAIL stray_fire u0: got fire=1 expected 0 without done");
      end
      if (done1) begin
        on_done(1, int'($signed(pot1)), fire1, busy1, mask[1]);
        mask[1] = '0;
      end else if (fire1) begin
        checks++; errors++;
        $display("FAIL stray_fire u1: got fire=1 expected 0 without done");
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, " pot0"}, pot0, 0);   chk({tag, " pot1"}, pot1, 0);
    chk({tag, " fire0"}, fire0, 0); chk({tag, " done0"}, done0, 0);
    chk({tag, " busy0"}, busy0, 0); chk({tag, " busy1"}, busy1, 0);
    chk({tag, " rd_en0"}, rd_en0, 0); chk({tag, " addr0"}, addr0, 0);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20 && dones[0] == d0; i++) tick();
    chk("done_seen", dones[0] - d0, 1);
  endtask

  // mode: 0 = spike cleared after start, 1 = junk after start, 2 = extra starts at E2/E4
  task automatic issue(input logic [N-1:0] sp, input int mode);
    exp_t e;
    int   np;
    bit   f;
    int   d0;
    for (int u = 0; u < 2; u++) begin
      model(sp, ths[u], model_pot[u], np, f);
      e.pot = np; e.fire = f; e.mask = sp; e.cyc = cyc;
      if (u == 0) q0.push_back(e); else q1.push_back(e);
      model_pot[u] = np;
    end
    d0    = dones[0];
    start = 1'b1;
    spike = sp;
    tick();
    start = 1'b0;
    spike = (mode == 1) ? N'($urandom) : '0;
    chk("busy_after_start", busy0, 1);
    if (mode == 2) begin
      tick();
      start = 1'b1; spike = ~sp;
      tick();
      start = 1'b0; spike = '0;
      tick();
      start = 1'b1; spike = N'($urandom);
      tick();
      start = 1'b0; spike = '0;
    end
    wait_done(d0);
    tick();
  endtask

  task automatic set_default_weights();
    w[0] = 5; w[1] = -3; w[2] = 7; w[3] = 2;
  endtask

  initial begin
    int dbase;
    rst_n = 1'b0;
    start = 1'b0;
    spike = '0;
    set_default_weights();
    repeat (3) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Fire: axons 0 and 2 -> 0 + 12 - 1 = 11.
    issue(4'b0101, 0);
    chk("fire_case_pot0", int'($signed(pot0)), 0);
    // Integrate: +5-1 per step -> 4, 8, then 12 fires.
    repeat (3) issue(4'b0001, 0);
    // Empty vector -> leak only.
    issue(4'b0000, 0);
    chk("empty_pot0", int'($signed(pot0)), -1);
    // Upstream clear race: spike dropped right after the start edge.
    issue(4'b1111, 0);
    // Extra starts mid-scan must be ignored, yielding a single done.
    dbase = dones[0];
    issue(4'b0110, 2);
    repeat (10) tick();
    chk("single_done", dones[0] - dbase, 1);

    // Saturation low, twice, then saturation high.
    for (int k = 0; k < N; k++) w[k] = -32768;
    issue(4'b1111, 0);
    issue(4'b1111, 0);
    chk("sat_low_pot0", int'($signed(pot0)), -32768);
    for (int k = 0; k < N; k++) w[k] = 32767;
    issue(4'b1111, 0);

    // Reset at E3 of a scan aborts it without a done.
    set_default_weights();
    dbase = dones[0];
    start = 1'b1; spike = 4'b0101;
    tick();
    start = 1'b0; spike = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    tick();
    check_zero_outputs("mid_reset");
    model_pot[0] = 0;
    model_pot[1] = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("no_done_after_abort", dones[0] - dbase, 0);
    issue(4'b0101, 0);

    // Randomized timesteps with occasional extreme weights and junk after start.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 4) == 0) w[k] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        else w[k] = int'($urandom_range(0, 200)) - 100;
      end
      issue(N'($urandom), 1);
    end

    repeat (5) tick();
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
